adc_sample_averager: RTL and testbench

ADC_SAMPLE_AVERAGER -- requirements
Module: adc_sample_averager

---
 rtl/adc_sample_averager.sv | 227 ++++++++++++++++++++++
 tb/tb_adc_sample_averager.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/adc_sample_averager.sv
// adc_sample_averager: per-channel boxcar averager fed by an ADC response
// stream, with an Avalon-MM register file for control, status and results.
module adc_sample_averager #(
  parameter int NUM_CH   = 8,
  parameter int DATA_W   = 12,
  parameter int LOG2_AVG = 4,
  parameter int ADDR_W   = 10
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic              s_valid,
  input  logic [4:0]        s_channel,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_startofpacket,
  input  logic              s_endofpacket,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [15:0]       avs_writedata,
  input  logic [1:0]        avs_byteenable,
  input  logic              avs_burstcount,
  input  logic              avs_debugaccess,
  output logic [15:0]       avs_readdata,
  output logic              avs_readdatavalid,
  output logic              avs_waitrequest,
  output logic              irq
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W = (LOG2_AVG > 0) ? LOG2_AVG : 1;
  localparam int ACC_W = DATA_W + LOG2_AVG;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << LOG2_AVG) - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    CLEAR = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [CH_W-1:0]   clrIdx_q, clrIdx_d;
  logic [1:0]        rstSync_q;
  logic              rstN;
  logic              en_q, en_d, cont_q, cont_d, irqEn_q, irqEn_d;
  logic              done_q, done_d, ovr_q, ovr_d, bad_q, bad_d;
  logic              doneEvent;
  logic [NUM_CH-1:0] seen_q, seen_d, seenNext, resultMask;
  logic [ACC_W-1:0]  acc_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [DATA_W-1:0] result_q [NUM_CH];
  logic [NUM_CH-1:0] fresh_q;
  logic [15:0]       readdata_q, rdWord;
  logic              readdatavalid_q;

  logic              wrAccept, rdAccept, wrEn, wrCtrl, wrStatus;
  logic              isResAddr, rdResult;
  logic [CH_W-1:0]   rdCh, sampleCh;
  logic              chInRange, sampleAccept, badSample, sampleLast, ovrEvent;
  logic [ACC_W-1:0]  sampleSum;
  logic [DATA_W-1:0] newResult;
  logic              unusedBits;

  assign unusedBits = ^{avs_writedata[15:4], avs_byteenable[1], avs_burstcount,
                        avs_debugaccess, s_startofpacket, s_endofpacket};

  // Reset asserts immediately but is released only on a clock edge.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) rstSync_q <= 2'b00;
    else                rstSync_q <= {rstSync_q[0], 1'b1};
  end
  assign rstN = rstSync_q[1];

  assign avs_waitrequest = (state_q == CLEAR);
  assign wrAccept  = avs_write && !avs_waitrequest;
  assign rdAccept  = avs_read && !avs_waitrequest;
  assign wrEn      = wrAccept && avs_byteenable[0];
  assign wrCtrl    = wrEn && (avs_address == '0);
  assign wrStatus  = wrEn && (avs_address == ADDR_W'(1));
  assign isResAddr = (avs_address >= ADDR_W'(2)) && (avs_address < ADDR_W'(NUM_CH + 2));
  assign rdCh      = CH_W'(avs_address - ADDR_W'(2));
  assign rdResult  = rdAccept && !avs_write && isResAddr;

  assign chInRange    = {1'b0, s_channel} < 6'(NUM_CH);
  assign sampleCh     = CH_W'(s_channel);
  assign sampleAccept = (state_q == RUN) && s_valid && chInRange;
  assign badSample    = (state_q == RUN) && s_valid && !chInRange;
  assign sampleLast   = sampleAccept && (cnt_q[sampleCh] == CNT_LAST);
  assign sampleSum    = acc_q[sampleCh] + ACC_W'(s_data);
  assign newResult    = DATA_W'(sampleSum >> LOG2_AVG);
  assign ovrEvent     = sampleLast && fresh_q[sampleCh];
  assign resultMask   = sampleLast ? (NUM_CH'(1) << sampleCh) : '0;
  assign seenNext     = seen_q | resultMask;

  // Next-state logic; a clear request overrides every other transition.
  always_comb begin
    state_d   = state_q;
    clrIdx_d  = clrIdx_q;
    doneEvent = 1'b0;
    unique case (state_q)
      IDLE:  if (wrCtrl && avs_writedata[0]) state_d = RUN;
      RUN: begin
        if (wrCtrl && !avs_writedata[0]) begin
          state_d = IDLE;
        end else if (!cont_q && (&seenNext)) begin
          state_d   = DONE;
          doneEvent = 1'b1;
        end
      end
      DONE:  if (wrCtrl && avs_writedata[0]) state_d = RUN;
      CLEAR: begin
        clrIdx_d = clrIdx_q + CH_W'(1);
        if (clrIdx_q == CH_W'(NUM_CH - 1)) begin
          state_d  = IDLE;
          clrIdx_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (wrCtrl && avs_writedata[2]) begin
      state_d   = CLEAR;
      clrIdx_d  = '0;
      doneEvent = 1'b0;
    end
  end

  // Control and status register next values; setting beats W1C.
  always_comb begin
    en_d    = en_q;
    cont_d  = cont_q;
    irqEn_d = irqEn_q;
    if (wrCtrl) begin
      en_d    = avs_writedata[0] & ~avs_writedata[2];
      cont_d  = avs_writedata[1];
      irqEn_d = avs_writedata[3];
    end
    if (doneEvent) en_d = 1'b0;
    done_d = (done_q & ~(wrStatus & avs_writedata[1])) | doneEvent;
    ovr_d  = (ovr_q  & ~(wrStatus & avs_writedata[2])) | ovrEvent;
    bad_d  = (bad_q  & ~(wrStatus & avs_writedata[3])) | badSample;
    seen_d = (state_q == RUN) ? seenNext : '0;
  end

  // State, control and status registers.
  always_ff @(posedge clk_clk or negedge rstN) begin
    if (!rstN) begin
      state_q  <= IDLE;
      clrIdx_q <= '0;
      en_q     <= 1'b0;
      cont_q   <= 1'b0;
      irqEn_q  <= 1'b0;
      done_q   <= 1'b0;
      ovr_q    <= 1'b0;
      bad_q    <= 1'b0;
      seen_q   <= '0;
    end else begin
      state_q  <= state_d;
      clrIdx_q <= clrIdx_d;
      en_q     <= en_d;
      cont_q   <= cont_d;
      irqEn_q  <= irqEn_d;
      done_q   <= done_d;
      ovr_q    <= ovr_d;
      bad_q    <= bad_d;
      seen_q   <= seen_d;
    end
  end

  // Per-channel accumulate/publish datapath, wiped one channel per cycle in CLEAR.
  always_ff @(posedge clk_clk or negedge rstN) begin
    if (!rstN) begin
      for (int i = 0; i < NUM_CH; i++) begin
        acc_q[i]    <= '0;
        cnt_q[i]    <= '0;
        result_q[i] <= '0;
      end
      fresh_q <= '0;
    end else if (state_q == CLEAR) begin
      acc_q[clrIdx_q]    <= '0;
      cnt_q[clrIdx_q]    <= '0;
      result_q[clrIdx_q] <= '0;
      fresh_q[clrIdx_q]  <= 1'b0;
    end else begin
      if (rdResult) fresh_q[rdCh] <= 1'b0;
      if (sampleAccept) begin
        if (sampleLast) begin
          result_q[sampleCh] <= newResult;
          fresh_q[sampleCh]  <= 1'b1;
          acc_q[sampleCh]    <= '0;
          cnt_q[sampleCh]    <= '0;
        end else begin
          acc_q[sampleCh] <= sampleSum;
          cnt_q[sampleCh] <= cnt_q[sampleCh] + CNT_W'(1);
        end
      end
    end
  end

  // Register read multiplexer.
  always_comb begin
    rdWord = '0;
    if (avs_address == '0) begin
      rdWord[3:0] = {irqEn_q, 1'b0, cont_q, en_q};
    end else if (avs_address == ADDR_W'(1)) begin
      rdWord[3:0] = {bad_q, ovr_q, done_q, (state_q == RUN) || (state_q == CLEAR)};
    end else if (isResAddr) begin
      rdWord     = 16'(result_q[rdCh]);
      rdWord[15] = fresh_q[rdCh];
    end
  end

  // Fixed one-cycle read pipeline; a read colliding with a write returns zero.
  always_ff @(posedge clk_clk or negedge rstN) begin
    if (!rstN) begin
      readdata_q      <= '0;
      readdatavalid_q <= 1'b0;
    end else begin
      readdatavalid_q <= rdAccept;
      if (rdAccept) readdata_q <= avs_write ? 16'h0000 : rdWord;
    end
  end

  assign avs_readdata      = readdata_q;
  assign avs_readdatavalid = readdatavalid_q;
  assign irq               = irqEn_q & (done_q | ovr_q);

endmodule

// File: tb/tb_adc_sample_averager.sv
// tb_adc_sample_averager: directed self-checking bench; unit A runs the
// default 16-sample averaging, unit B runs LOG2_AVG=0 for single-shot checks.
module tb_adc_sample_averager;

  localparam logic [9:0] A_CTRL = 10'd0;
  localparam logic [9:0] A_STAT = 10'd1;
  localparam logic [9:0] A_RES  = 10'd2;

  logic        clk = 1'b0;
  logic        rstN;
  logic        sel;
  logic [9:0]  addr;
  logic [15:0] wdata;
  logic [1:0]  be;
  logic        rd, wr, sv;
  logic [4:0]  sch;
  logic [11:0] sdata;

  logic [15:0] rdataA, rdataB, rdata;
  logic        rdvA, rdvB, rdv, wrqA, wrqB, wrq, irqA, irqB, irqS;

  int nChecks = 0;
  int nFail   = 0;

  always #5 clk = ~clk;

  assign rdata = sel ? rdataB : rdataA;
  assign rdv   = sel ? rdvB   : rdvA;
  assign wrq   = sel ? wrqB   : wrqA;
  assign irqS  = sel ? irqB   : irqA;

  adc_sample_averager #(.NUM_CH(8), .DATA_W(12), .LOG2_AVG(4), .ADDR_W(10)) dutA (
    .clk_clk(clk), .reset_reset_n(rstN),
    .s_valid(sv && !sel), .s_channel(sch), .s_data(sdata),
    .s_startofpacket(1'b0), .s_endofpacket(1'b0),
    .avs_address(addr), .avs_read(rd && !sel), .avs_write(wr && !sel),
    .avs_writedata(wdata), .avs_byteenable(be),
    .avs_burstcount(1'b1), .avs_debugaccess(1'b0),
    .avs_readdata(rdataA), .avs_readdatavalid(rdvA), .avs_waitrequest(wrqA),
    .irq(irqA)
  );

  adc_sample_averager #(.NUM_CH(8), .DATA_W(12), .LOG2_AVG(0), .ADDR_W(10)) dutB (
    .clk_clk(clk), .reset_reset_n(rstN),
    .s_valid(sv && sel), .s_channel(sch), .s_data(sdata),
    .s_startofpacket(1'b0), .s_endofpacket(1'b0),
    .avs_address(addr), .avs_read(rd && sel), .avs_write(wr && sel),
    .avs_writedata(wdata), .avs_byteenable(be),
    .avs_burstcount(1'b1), .avs_debugaccess(1'b0),
    .avs_readdata(rdataB), .avs_readdatavalid(rdvB), .avs_waitrequest(wrqB),
    .irq(irqB)
  );

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s observed=0x%04h expected=0x%04h", tag, obs, exp);
    end
  endtask

  // Drive bus and stream for one clock cycle, starting and ending on a negedge.
  task automatic applyStimulus(input logic doRd, input logic doWr, input logic [9:0] a,
                               input logic [15:0] d, input logic doS, input logic [4:0] ch,
                               input logic [11:0] data);
    rd = doRd; wr = doWr; addr = a; wdata = d;
    sv = doS; sch = ch; sdata = data;
    @(negedge clk);
    rd = 1'b0; wr = 1'b0; sv = 1'b0;
  endtask

  task automatic busWrite(input logic [9:0] a, input logic [15:0] d);
    applyStimulus(1'b0, 1'b1, a, d, 1'b0, 5'd0, 12'h000);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 10'd0, 16'h0, 1'b0, 5'd0, 12'h000);
  endtask

  task automatic readCheck(input string tag, input logic [9:0] a, input logic [15:0] exp);
    applyStimulus(1'b1, 1'b0, a, 16'h0, 1'b0, 5'd0, 12'h000);
    checkOutput({tag, "_valid"}, 16'(rdv), 16'h0001);
    checkOutput(tag, rdata, exp);
  endtask

  task automatic sendRun(input logic [4:0] ch, input logic [11:0] base,
                         input logic [11:0] step, input int n);
    for (int i = 0; i < n; i++)
      applyStimulus(1'b0, 1'b0, 10'd0, 16'h0, 1'b1, ch, base + 12'(i) * step);
  endtask

  initial begin
    sel = 1'b0; be = 2'b01; rd = 1'b0; wr = 1'b0; sv = 1'b0;
    addr = '0; wdata = '0; sch = '0; sdata = '0;
    rstN = 1'b1;
    #2 rstN = 1'b0;
    repeat (3) @(negedge clk);
    $display("[TB] reset state");
    checkOutput("rst_readdata", rdata, 16'h0000);
    checkOutput("rst_rdvalid", 16'(rdv), 16'h0000);
    checkOutput("rst_waitreq", 16'(wrq), 16'h0000);
    checkOutput("rst_irq", 16'(irqS), 16'h0000);
    rstN = 1'b1;
    idle(3);
    readCheck("ctrl_after_reset", A_CTRL, 16'h0000);
    readCheck("status_after_reset", A_STAT, 16'h0000);

    $display("[TB] byteenable gating");
    be = 2'b10;
    busWrite(A_CTRL, 16'h0003);
    be = 2'b01;
    readCheck("ctrl_be_ignored", A_CTRL, 16'h0000);

    $display("[TB] continuous averaging on ch2");
    busWrite(A_CTRL, 16'h0003);
    readCheck("ctrl_run", A_CTRL, 16'h0003);
    readCheck("status_busy", A_STAT, 16'h0001);
    sendRun(5'd2, 12'h100, 12'h001, 16);
    readCheck("res2_first", A_RES + 10'd2, 16'h8107);
    readCheck("res2_second", A_RES + 10'd2, 16'h0107);

    $display("[TB] read colliding with window completion on ch3");
    sendRun(5'd3, 12'h020, 12'h000, 16);
    readCheck("res3_old", A_RES + 10'd3, 16'h8020);
    sendRun(5'd3, 12'h040, 12'h000, 15);
    applyStimulus(1'b1, 1'b0, A_RES + 10'd3, 16'h0, 1'b1, 5'd3, 12'h040);
    checkOutput("res3_collide", rdata, 16'h0020);
    readCheck("res3_new", A_RES + 10'd3, 16'h8040);

    $display("[TB] overrun and bad channel");
    sendRun(5'd5, 12'h010, 12'h000, 16);
    sendRun(5'd5, 12'h030, 12'h000, 16);
    readCheck("status_overrun", A_STAT, 16'h0005);
    checkOutput("irq_masked", 16'(irqS), 16'h0000);
    readCheck("res5", A_RES + 10'd5, 16'h8030);
    sendRun(5'd9, 12'hFFF, 12'h000, 16);
    readCheck("status_bad", A_STAT, 16'h000D);
    readCheck("res1_untouched", A_RES + 10'd1, 16'h0000);
    readCheck("res5_untouched", A_RES + 10'd5, 16'h0030);
    busWrite(A_CTRL, 16'h000B);
    checkOutput("irq_overrun", 16'(irqS), 16'h0001);
    busWrite(A_STAT, 16'h000C);
    checkOutput("irq_after_w1c", 16'(irqS), 16'h0000);
    readCheck("status_after_w1c", A_STAT, 16'h0001);

    $display("[TB] clear sweep");
    busWrite(A_CTRL, 16'h0004);
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("clear_wait_%0d", i), 16'(wrq), 16'h0001);
      applyStimulus(1'b0, 1'b0, 10'd0, 16'h0, (i == 4), 5'd2, 12'hABC);
    end
    checkOutput("clear_wait_end", 16'(wrq), 16'h0000);
    readCheck("ctrl_after_clear", A_CTRL, 16'h0000);
    readCheck("status_after_clear", A_STAT, 16'h0000);
    readCheck("res2_cleared", A_RES + 10'd2, 16'h0000);
    readCheck("res3_cleared", A_RES + 10'd3, 16'h0000);
    readCheck("res5_cleared", A_RES + 10'd5, 16'h0000);
    busWrite(A_CTRL, 16'h0003);
    sendRun(5'd2, 12'h050, 12'h000, 16);
    readCheck("res2_post_clear", A_RES + 10'd2, 16'h8050);

    $display("[TB] clear and enable in one write");
    busWrite(A_CTRL, 16'h0005);
    idle(9);
    readCheck("ctrl_clear_wins", A_CTRL, 16'h0000);
    readCheck("status_clear_wins", A_STAT, 16'h0000);

    $display("[TB] reset mid-window");
    busWrite(A_CTRL, 16'h0003);
    sendRun(5'd0, 12'hFFF, 12'h000, 7);
    rstN = 1'b0;
    #1;
    checkOutput("midrst_readdata", rdata, 16'h0000);
    checkOutput("midrst_rdvalid", 16'(rdv), 16'h0000);
    checkOutput("midrst_irq", 16'(irqS), 16'h0000);
    repeat (3) @(negedge clk);
    rstN = 1'b1;
    idle(3);
    readCheck("ctrl_after_midrst", A_CTRL, 16'h0000);
    readCheck("res2_after_midrst", A_RES + 10'd2, 16'h0000);
    busWrite(A_CTRL, 16'h0003);
    sendRun(5'd0, 12'h0FF, 12'h000, 16);
    readCheck("res0_after_midrst", A_RES, 16'h80FF);

    $display("[TB] single-shot with one-sample windows");
    sel = 1'b1;
    busWrite(A_CTRL, 16'h0009);
    readCheck("b_status_busy", A_STAT, 16'h0001);
    for (int c = 0; c < 7; c++)
      applyStimulus(1'b0, 1'b0, 10'd0, 16'h0, 1'b1, 5'(c), 12'h010 + 12'(c));
    readCheck("b_status_7ch", A_STAT, 16'h0001);
    applyStimulus(1'b0, 1'b0, 10'd0, 16'h0, 1'b1, 5'd7, 12'h017);
    readCheck("b_status_done", A_STAT, 16'h0002);
    readCheck("b_ctrl_selfclear", A_CTRL, 16'h0008);
    checkOutput("b_irq_done", 16'(irqS), 16'h0001);
    readCheck("b_res4", A_RES + 10'd4, 16'h8014);
    readCheck("b_res7", A_RES + 10'd7, 16'h8017);
    busWrite(A_STAT, 16'h0002);
    checkOutput("b_irq_cleared", 16'(irqS), 16'h0000);
    readCheck("b_status_cleared", A_STAT, 16'h0000);
    applyStimulus(1'b1, 1'b1, A_CTRL, 16'h0009, 1'b0, 5'd0, 12'h000);
    checkOutput("b_rdwr_valid", 16'(rdv), 16'h0001);
    checkOutput("b_rdwr_data", rdata, 16'h0000);
    readCheck("b_status_rerun", A_STAT, 16'h0001);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
